// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: address width, reset vector and PC FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = '0;

  typedef enum logic [0:0] {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_t;

endpackage

// File: rtl/inc16.sv
// Combinational WIDTH-bit incrementer built as a ripple chain of half adders.
// carry_out is high only when the input is all ones (the result wraps to zero).
module inc16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  // The constant carry-in of 1 turns the half-adder chain into +1
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_half_adder
    assign sum[i]     = a[i] ^ carry[i];
    assign carry[i+1] = a[i] & carry[i];
  end

  assign carry_out = carry[WIDTH];

endmodule

// File: rtl/program_counter.sv
// Program counter stage: reset / load / increment / hold with a RUN/HALTED FSM.
// Optional sticky wrap flag enabled by defining PC_WRAP_FLAG_EN.
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned       WIDTH      = ADDR_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_ADDR = WIDTH'(cpu_pkg::RESET_ADDR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             halt,
  input  logic             resume,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             running
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrapped
`endif
);

  pc_state_t        state;
  logic [WIDTH-1:0] inc_sum;

`ifdef PC_WRAP_FLAG_EN
  logic inc_carry;
`else
  logic unused_inc_carry;
`endif

  inc16 #(
    .WIDTH(WIDTH)
  ) u_inc16 (
    .a        (out),
    .sum      (inc_sum),
`ifdef PC_WRAP_FLAG_EN
    .carry_out(inc_carry)
`else
    .carry_out(unused_inc_carry)
`endif
  );

  // FSM, address register and registered status outputs updated together
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PC_RUN;
      out     <= RESET_ADDR;
      running <= 1'b1;
`ifdef PC_WRAP_FLAG_EN
      wrapped <= 1'b0;
`endif
    end else begin
      unique case (state)
        PC_RUN: begin
          // Halt freezes out in the very cycle it is sampled
          if (halt) begin
            state   <= PC_HALTED;
            running <= 1'b0;
          end else if (load) begin
            out <= in;
`ifdef PC_WRAP_FLAG_EN
            wrapped <= 1'b0;
`endif
          end else if (inc) begin
            out <= inc_sum;
`ifdef PC_WRAP_FLAG_EN
            if (inc_carry) wrapped <= 1'b1;
`endif
          end
        end
        PC_HALTED: begin
          // Halt wins a tie with resume
          if (resume && !halt) begin
            state   <= PC_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= PC_RUN;
          running <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test-plan steps followed by
// randomized stimulus against a behavioural model. Define PC_WRAP_FLAG_EN to
// also check the wrap flag.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        inc = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic        running;
`ifdef PC_WRAP_FLAG_EN
  logic        wrapped;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_pc   = 0;
  bit          m_run  = 1'b1;
  bit          m_wrap = 1'b0;

  always #5 clk = ~clk;

  program_counter #(
    .WIDTH     (16),
    .RESET_ADDR(16'h0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .inc    (inc),
    .halt   (halt),
    .resume (resume),
    .in     (in),
    .out    (out),
    .running(running)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrapped(wrapped)
`endif
  );

  // Model of one clock edge, written from the behavioural rules
  task automatic model_edge(input bit r, input bit l, input bit i, input bit h,
                            input bit rs, input logic [15:0] d);
    if (r) begin
      m_pc   = 0;
      m_run  = 1'b1;
      m_wrap = 1'b0;
    end else if (m_run) begin
      if (h) begin
        m_run = 1'b0;
      end else if (l) begin
        m_pc   = int'(d);
        m_wrap = 1'b0;
      end else if (i) begin
        if (m_pc == 65535) m_wrap = 1'b1;
        m_pc = (m_pc + 1) % 65536;
      end
    end else if (rs && !h) begin
      m_run = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (out === 16'(m_pc)) else begin
      errors++;
      $error("FAIL %s out=%h expected=%h", tag, out, 16'(m_pc));
    end
    checks++;
    assert (running === m_run) else begin
      errors++;
      $error("FAIL %s running=%b expected=%b", tag, running, m_run);
    end
`ifdef PC_WRAP_FLAG_EN
    checks++;
    assert (wrapped === m_wrap) else begin
      errors++;
      $error("FAIL %s wrapped=%b expected=%b", tag, wrapped, m_wrap);
    end
`endif
  endtask

  // Direct comparison against a literal value from the test plan
  task automatic expect_out(input string tag, input logic [15:0] exp_out, input bit exp_run);
    checks++;
    assert (out === exp_out && running === exp_run) else begin
      errors++;
      $error("FAIL %s out=%h running=%b expected out=%h running=%b",
             tag, out, running, exp_out, exp_run);
    end
  endtask

  // Apply inputs, advance one edge, then compare away from the edge
  task automatic step(input string tag, input bit r, input bit l, input bit i, input bit h,
                      input bit rs, input logic [15:0] d);
    reset  = r;
    load   = l;
    inc    = i;
    halt   = h;
    resume = rs;
    in     = d;
    model_edge(r, l, i, h, rs, d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [15:0] rd;
    #2;
    // Reset then five increments
    step("reset", 1, 0, 0, 0, 0, 16'h0);
    expect_out("reset_val", 16'h0000, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step("inc_seq", 0, 0, 1, 0, 0, 16'h0);
      expect_out("inc_seq_val", 16'(k), 1'b1);
    end

    // Load wins over inc
    step("load_inc", 0, 1, 1, 0, 0, 16'h1234);
    expect_out("load_wins", 16'h1234, 1'b1);
    step("inc_after_load", 0, 0, 1, 0, 0, 16'h0);
    expect_out("inc_after_load_val", 16'h1235, 1'b1);

    // Halt path
    step("load_10", 0, 1, 0, 0, 0, 16'h0010);
    step("halt_inc", 0, 0, 1, 1, 0, 16'h0);
    expect_out("halt_freeze", 16'h0010, 1'b0);
    step("halted_load", 0, 1, 0, 0, 0, 16'h00AA);
    expect_out("halted_load_ignored", 16'h0010, 1'b0);
    step("halted_inc", 0, 0, 1, 0, 0, 16'h0);
    step("tie", 0, 0, 0, 1, 1, 16'h0);
    expect_out("tie_stays_halted", 16'h0010, 1'b0);
    step("resume", 0, 0, 0, 0, 1, 16'h0);
    expect_out("resumed", 16'h0010, 1'b1);
    step("inc_after_resume", 0, 0, 1, 0, 0, 16'h0);
    expect_out("inc_after_resume_val", 16'h0011, 1'b1);

    // Wrap-around
    step("load_ffff", 0, 1, 0, 0, 0, 16'hFFFF);
    step("wrap", 0, 0, 1, 0, 0, 16'h0);
    expect_out("wrap_val", 16'h0000, 1'b1);
    step("post_wrap_inc", 0, 0, 1, 0, 0, 16'h0);
    step("post_wrap_inc2", 0, 0, 1, 0, 0, 16'h0);
    expect_out("post_wrap_val", 16'h0002, 1'b1);
    step("load_clears", 0, 1, 0, 0, 0, 16'h0005);
    step("load_zero", 0, 1, 0, 0, 0, 16'h0000);

    // Reset while halted
    step("load_42", 0, 1, 0, 0, 0, 16'h0042);
    step("halt_42", 0, 0, 0, 1, 0, 16'h0);
    expect_out("halted_42", 16'h0042, 1'b0);
    step("reset_halted", 1, 0, 0, 1, 1, 16'h0);
    expect_out("reset_from_halt", 16'h0000, 1'b1);

    // Reset beats load
    step("inc_pre", 0, 0, 1, 0, 0, 16'h0);
    step("reset_load", 1, 1, 1, 0, 0, 16'hBEEF);
    expect_out("reset_wins", 16'h0000, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'hFFFF;
        1:       rd = 16'hFFFD;
        default: rd = 16'($urandom);
      endcase
      step("random",
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0,
           rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter stage for the CPU datapath, built on the gate-level primitives (And and related gates) for its control decode.
- Holds the current instruction address and selects, every cycle, one of: reset to zero, load of a jump target, increment, or hold.
- Feeds the instruction-memory address port.
- Its load/inc controls are driven by the jump-condition logic (And/Or gate network) downstream of the ALU flags.

Parameters:
- WIDTH, 16, address width in bits.
- RESET_ADDR, 0, value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load jump target `in` this cycle.
- inc  input  1  increment address this cycle.
- halt  input  1  request transition to HALTED.
- resume  input  1  request transition from HALTED back to RUN.
- in  input  WIDTH  jump target address.
- out  output  WIDTH  current PC value (registered).
- running  output  1  1 when the FSM is in RUN (registered).

Behaviour:
- Clocking and reset: one clock `clk`. Reset is synchronous and active-high, sampled only at the rising edge of `clk`.
- Reset values: out = RESET_ADDR, running = 1, FSM = RUN. Reset has priority over all other inputs, including halt and resume.
- FSM states: RUN, HALTED.
  - RUN -> HALTED when halt = 1.
  - HALTED -> RUN when resume = 1 and halt = 0.
  - halt and resume both 1 resolves to HALTED (halt wins).
- Update in RUN, by priority:
  - load = 1: out <= in.
  - else inc = 1: out <= out + 1.
  - else: out holds.
  - If load and inc are both 1, load wins.
- Update in HALTED: out holds regardless of load and inc. Only reset changes out.
- Halt takes effect from the cycle it is sampled. In the cycle where halt = 1 in RUN, out does not update even if load or inc is asserted.
- Latency: one cycle. The value selected at edge N appears on out immediately after edge N; there is no combinational path from inputs to out.
- Arithmetic: increment is modulo 2^WIDTH. 16'hFFFF + 1 wraps to 16'h0000 with no flag, unless the optional feature is enabled.
- running mirrors the FSM state: 1 in RUN, 0 in HALTED. It changes in the same cycle as the state.
- Reset mid-operation (including while HALTED): next cycle, out = RESET_ADDR, running = 1, FSM = RUN.
- No X propagation: all state registers are reset, and `in` is only sampled when load = 1 in RUN.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- When defined:
  - Adds output port `wrapped` (1 bit, registered, reset 0).
  - `wrapped` is set sticky to 1 when an increment takes out from all-ones to zero.
  - It is cleared only by reset or by a load.
  - A load of 0 does not set it.
- When undefined: the port and its logic are absent, and wrap-around is silent.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_WIDTH = 16.
  - RESET_ADDR constant.
  - pc_state_t enum {PC_RUN, PC_HALTED}.
- Sub-module inc16: a pure combinational WIDTH-bit incrementer (carry chain of half adders from the gate library). It exposes carry_out, which the optional wrap flag uses.

Test Plan:
- Reset then inc = 1 for 5 cycles -> out sequence 0, 1, 2, 3, 4, 5; running = 1 throughout.
- load = 1, in = 16'h1234, with inc = 1 in the same cycle -> out = 16'h1234 next cycle (load wins); following cycle with inc only -> 16'h1235.
- Halt path:
  - At out = 16'h0010, assert halt with inc = 1 -> out stays 16'h0010 and running = 0 next cycle.
  - With load = 1, in = 16'h00AA while HALTED -> out unchanged.
  - resume = 1 -> running = 1; the next inc gives 16'h0011.
- Halt/resume tie: in HALTED, assert halt = 1 and resume = 1 together -> remains HALTED, running = 0.
- Wrap: load 16'hFFFF, then inc -> out = 16'h0000. With PC_WRAP_FLAG_EN, wrapped = 1 and stays 1 through further incs; a subsequent load clears it to 0.
- Reset mid-operation:
  - reset asserted while HALTED at out = 16'h0042 -> next cycle out = 16'h0000, running = 1 (and wrapped = 0 when the feature is enabled).
  - reset and load asserted in the same cycle -> reset wins.
